// File: rtl/kgp_pkg.sv
// Shared KGP (kill / generate / propagate) definitions for the prefix adder.
// Encoding: K = 00, P = 01 or 10 (either means propagate), G = 11.
package kgp_pkg;

    typedef logic [1:0] kgp_t;

    localparam kgp_t KGP_K     = 2'b00;
    localparam kgp_t KGP_P     = 2'b01;
    localparam kgp_t KGP_P_ALT = 2'b10;
    localparam kgp_t KGP_G     = 2'b11;

    // A group propagates when exactly one of its two code bits is set.
    function automatic logic kgpIsProp(input kgp_t grp);
        return grp[1] ^ grp[0];
    endfunction

    // Per-bit encoding: {a&b, a|b} gives 11 = G, 00 = K, 01 = P.
    function automatic kgp_t kgpEncode(input logic aBit, input logic bBit);
        return {aBit & bBit, aBit | bBit};
    endfunction

    // Combine a higher group with the adjacent lower group: a K or G
    // high part decides on its own, a propagating one passes the low part.
    function automatic kgp_t kgpCombine(input kgp_t hi, input kgp_t lo);
        return kgpIsProp(hi) ? lo : hi;
    endfunction

    // Carry out of a resolved group; a still-propagating group passes c0.
    function automatic logic kgpCarry(input kgp_t grp, input logic c0);
        return kgpIsProp(grp) ? c0 : grp[1];
    endfunction

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kgp_prefix_level.sv
// One Kogge-Stone combine level: every position at or above DIST merges
// with the group DIST positions below it; lower positions pass through.
module kgp_prefix_level
    import kgp_pkg::*;
#(
    parameter int N    = 33,
    parameter int DIST = 1
) (
    input  kgp_t [N-1:0] grp_i,
    output kgp_t [N-1:0] grp_o
);

    for (genvar i = 0; i < N; i++) begin : genBit
        if (i >= DIST) begin : genCombine
            assign grp_o[i] = kgpCombine(grp_i[i], grp_i[i-DIST]);
        end else begin : genPass
            assign grp_o[i] = grp_i[i];
        end
    end

endmodule

// File: rtl/kgp_addsub_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Position 0 of the prefix vector carries c0 as bit -1, so after all levels
// position i+1 holds the resolved carry out of operand bit i.
module kgp_addsub_pipe
    import kgp_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LOG = clog2(WIDTH);
    localparam int NP  = (LOG + LVL_PER_STG - 1) / LVL_PER_STG;

    typedef kgp_t [WIDTH:0] grp_t;

    // Stage 0 holds the raw encoding, stages 1..NP the partially resolved prefix.
    grp_t             stgGrp_q   [NP+1];
    logic [WIDTH-1:0] stgProp_q  [NP+1];
    logic [NP:0]      stgValid_q;
    logic [NP:0]      stgC0_q;
    logic [NP:0]      stgSignA_q;
    logic [NP:0]      stgSignB_q;

    grp_t             stg0Grp_d;
    logic [WIDTH-1:0] stg0Prop_d;
    logic             stg0C0_d;
    logic             stg0SignA_d;
    logic             stg0SignB_d;

    grp_t             prefOut [NP];

    logic             outValid_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             adv;

    // Every stage moves together unless a finished result is stuck at the output.
    assign adv       = !outValid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = outValid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Effective operands and per-bit KGP encoding for the incoming operation.
    always_comb begin
        logic [WIDTH-1:0] bEff;
        bEff        = sub ? ~b : b;
        stg0C0_d    = sub | cin;
        stg0Grp_d   = '0;
        stg0Grp_d[0] = stg0C0_d ? KGP_G : KGP_K;
        for (int i = 0; i < WIDTH; i++) begin
            stg0Grp_d[i+1] = kgpEncode(a[i], bEff[i]);
        end
        stg0Prop_d  = a ^ bEff;
        stg0SignA_d = a[WIDTH-1];
        stg0SignB_d = bEff[WIDTH-1];
    end

    // Combine levels; each register stage feeds LVL_PER_STG consecutive levels.
    for (genvar l = 0; l < LOG; l++) begin : genLevel
        grp_t levelIn;
        grp_t levelOut;
        if (l % LVL_PER_STG == 0) begin : genFromReg
            assign levelIn = stgGrp_q[l / LVL_PER_STG];
        end else begin : genFromPrev
            assign levelIn = genLevel[l-1].levelOut;
        end
        kgp_prefix_level #(
            .N    (WIDTH + 1),
            .DIST (1 << l)
        ) uLevel (
            .grp_i (levelIn),
            .grp_o (levelOut)
        );
    end

    // Tap the last level belonging to each register stage.
    for (genvar s = 0; s < NP; s++) begin : genStageTap
        localparam int LAST = (((s + 1) * LVL_PER_STG < LOG) ? (s + 1) * LVL_PER_STG : LOG) - 1;
        assign prefOut[s] = genLevel[LAST].levelOut;
    end

    // Final stage: sum bits, carry-out, signed overflow and zero flag.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i] = stgProp_q[NP][i] ^ kgpCarry(stgGrp_q[NP][i], stgC0_q[NP]);
        end
        cout_d = kgpCarry(stgGrp_q[NP][WIDTH], stgC0_q[NP]);
        ovf_d  = (stgSignA_q[NP] == stgSignB_q[NP]) && (sum_d[WIDTH-1] != stgSignA_q[NP]);
        zero_d = ~|sum_d;
    end

    // Pipeline registers; everything, bubbles included, holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s <= NP; s++) begin
                stgGrp_q[s]  <= '0;
                stgProp_q[s] <= '0;
            end
            stgValid_q <= '0;
            stgC0_q    <= '0;
            stgSignA_q <= '0;
            stgSignB_q <= '0;
            outValid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (adv) begin
            stgValid_q[0] <= in_valid;
            stgGrp_q[0]   <= stg0Grp_d;
            stgProp_q[0]  <= stg0Prop_d;
            stgC0_q[0]    <= stg0C0_d;
            stgSignA_q[0] <= stg0SignA_d;
            stgSignB_q[0] <= stg0SignB_d;
            for (int s = 1; s <= NP; s++) begin
                stgValid_q[s] <= stgValid_q[s-1];
                stgGrp_q[s]   <= prefOut[s-1];
                stgProp_q[s]  <= stgProp_q[s-1];
                stgC0_q[s]    <= stgC0_q[s-1];
                stgSignA_q[s] <= stgSignA_q[s-1];
                stgSignB_q[s] <= stgSignB_q[s-1];
            end
            outValid_q <= stgValid_q[NP];
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_kgp_addsub_pipe.sv
// Scoreboard bench for kgp_addsub_pipe: a 32-bit/2-level instance and an
// 8-bit/1-level instance share stimulus and handshake (both have latency 5).
module tb_kgp_addsub_pipe;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b1;
    logic [31:0] aIn = '0;
    logic [31:0] bIn = '0;
    logic        cinIn = 1'b0;
    logic        subIn = 1'b0;

    logic        inReady32, outValid32, cout32, ovf32, zero32;
    logic [31:0] sum32;
    logic        inReady8, outValid8, cout8, ovf8, zero8;
    logic [7:0]  sum8;

    int assertCount = 0;
    int failCount = 0;
    exp_t q32[$];
    exp_t q8[$];

    function automatic int latencyOf(input int w, input int lvl);
        return ($clog2(w) + lvl - 1) / lvl + 2;
    endfunction

    localparam int L32 = latencyOf(32, 2);
    localparam int L8  = latencyOf(8, 1);

    always #5 clk = ~clk;

    kgp_addsub_pipe #(.WIDTH(32), .LVL_PER_STG(2)) uDut32 (
        .clk(clk), .reset(resetN), .in_valid(inValid), .in_ready(inReady32),
        .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
        .out_valid(outValid32), .out_ready(outReady),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    kgp_addsub_pipe #(.WIDTH(8), .LVL_PER_STG(1)) uDut8 (
        .clk(clk), .reset(resetN), .in_valid(inValid), .in_ready(inReady8),
        .a(aIn[7:0]), .b(bIn[7:0]), .cin(cinIn), .sub(subIn),
        .out_valid(outValid8), .out_ready(outReady),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    // Reference: true integer arithmetic, signed range check for overflow.
    function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub);
        exp_t   e;
        longint modulus, half, ua, ub, sa, sb, raw, sres;
        modulus = longint'(1) << w;
        half    = modulus / 2;
        ua      = longint'({32'b0, a}) % modulus;
        ub      = longint'({32'b0, b}) % modulus;
        sa      = (ua >= half) ? ua - modulus : ua;
        sb      = (ub >= half) ? ub - modulus : ub;
        if (sub) begin
            raw    = ua - ub;
            e.cout = (ua >= ub);
            sres   = sa - sb;
        end else begin
            raw    = ua + ub + (cin ? 1 : 0);
            e.cout = (raw >= modulus);
            sres   = sa + sb + (cin ? 1 : 0);
        end
        if (raw < 0) raw = raw + modulus;
        raw    = raw % modulus;
        e.sum  = 32'(raw);
        e.ovf  = (sres >= half) || (sres < -half);
        e.zero = (raw == 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for the 32-bit instance: compare head of queue, pop on transfer.
    always @(negedge clk) begin
        if (resetN && outValid32) begin
            if (q32.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_out32: got sum 0x%0h, expected no output", sum32);
            end else begin
                checkOutput("sum32", sum32, q32[0].sum);
                checkOutput("cout32", 32'(cout32), 32'(q32[0].cout));
                checkOutput("ovf32", 32'(ovf32), 32'(q32[0].ovf));
                checkOutput("zero32", 32'(zero32), 32'(q32[0].zero));
                checkOutput("in_ready32", 32'(inReady32), 32'(outReady));
                if (outReady) void'(q32.pop_front());
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (resetN && outValid8) begin
            if (q8.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_out8: got sum 0x%0h, expected no output", sum8);
            end else begin
                checkOutput("sum8", 32'(sum8), 32'(q8[0].sum[7:0]));
                checkOutput("cout8", 32'(cout8), 32'(q8[0].cout));
                checkOutput("ovf8", 32'(ovf8), 32'(q8[0].ovf));
                checkOutput("zero8", 32'(zero8), 32'(q8[0].zero));
                checkOutput("in_ready8", 32'(inReady8), 32'(outReady));
                if (outReady) void'(q8.pop_front());
            end
        end
    end

    // Present one operation and hold it until accepted; expectations are queued on acceptance.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int tries;
        bit accepted;
        tries    = 0;
        accepted = 0;
        aIn      = a;
        bIn      = b;
        cinIn    = cin;
        subIn    = sub;
        inValid  = 1'b1;
        while (!accepted) begin
            @(negedge clk);
            if (inReady32) begin
                q32.push_back(refModel(32, a, b, cin, sub));
                accepted = 1;
            end
            if (inReady8) q8.push_back(refModel(8, a, b, cin, sub));
            @(posedge clk);
            #1;
            if (!accepted) begin
                tries++;
                if (tries > 200) begin
                    checkOutput("accept_timeout", 32'(inReady32), 32'd1);
                    break;
                end
            end
        end
        inValid = 1'b0;
    endtask

    // Called right after an accepting edge with no stalls: count edges to out_valid.
    task automatic measureLatency(input string name);
        int lat;
        lat = 1;
        while (!outValid32 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput(name, 32'(lat), 32'(L32));
        checkOutput({name, "_w8"}, 32'(outValid8), 32'(L8 == lat));
    endtask

    task automatic drainAll();
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_q32", 32'(q32.size()), 32'd0);
        checkOutput("drain_q8", 32'(q8.size()), 32'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_00FF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit randDone;
        randDone = 0;

        // Reset state
        #1;
        checkOutput("reset_out_valid32", 32'(outValid32), 32'd0);
        checkOutput("reset_sum32", sum32, 32'd0);
        checkOutput("reset_flags32", {29'd0, cout32, ovf32, zero32}, 32'd0);
        checkOutput("reset_out_valid8", 32'(outValid8), 32'd0);
        checkOutput("reset_sum8", 32'(sum8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        #1;
        checkOutput("in_ready_after_reset", 32'(inReady32), 32'd1);
        @(posedge clk);
        #1;

        // Directed: basic add with latency, equal subtract, overflow, borrow
        $display("[TB] directed operations");
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        measureLatency("latency_add");
        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        drainAll();

        // Back-pressure: 8 back-to-back ops, out_ready low for 4 cycles
        $display("[TB] back-pressure");
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(32'(i), 32'(i), 1'b1, 1'b0);
            end
            begin
                int n;
                n = 0;
                while (!outValid32 && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                outReady = 1'b0;
                repeat (4) begin
                    #1;
                    checkOutput("bp_in_ready", 32'(inReady32), 32'd0);
                    @(posedge clk);
                    #1;
                end
                outReady = 1'b1;
            end
        join
        drainAll();

        // Reset with three operations in flight
        $display("[TB] reset mid-flight");
        applyStimulus(32'd10, 32'd20, 1'b0, 1'b0);
        applyStimulus(32'd30, 32'd40, 1'b0, 1'b0);
        applyStimulus(32'd50, 32'd60, 1'b0, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("midreset_out_valid32", 32'(outValid32), 32'd0);
        checkOutput("midreset_sum32", sum32, 32'd0);
        checkOutput("midreset_out_valid8", 32'(outValid8), 32'd0);
        q32.delete();
        q8.delete();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        #1;
        checkOutput("midreset_in_ready32", 32'(inReady32), 32'd1);
        checkOutput("midreset_in_ready8", 32'(inReady8), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(32'd1, 32'd1, 1'b0, 1'b0);
        measureLatency("latency_after_reset");
        drainAll();

        // Randomized traffic with random gaps and random back-pressure
        $display("[TB] randomized traffic");
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(pickOperand(), pickOperand(), 1'($urandom), 1'($urandom));
                end
                randDone = 1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1;
                    outReady = ($urandom_range(0, 3) != 0);
                end
                outReady = 1'b1;
            end
        join
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
